// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Producer handshake and FIFO write-port bundle for the
//               fifo_wr_arbiter. master = arbiter side, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          grant_valid;
    logic [IDW-1:0]                grant_id;
    logic                          fifo_cs;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_datain;
    logic                          fifo_full;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, grant_valid, grant_id, fifo_cs, fifo_wr_en, fifo_datain
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, grant_valid, grant_id, fifo_cs, fifo_wr_en, fifo_datain
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin, burst-bounded arbiter sharing one FIFO write port
//               between NUM_REQ valid/ready producers. Optional statistics
//               counters are enabled with the macro FIFO_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]        stall_cnt,
    output logic [15:0]        grant_cnt,
`endif
    fifo_wr_arbiter_if.master  bus
);

    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDW-1:0]   c_LAST_ID   = IDW'(NUM_REQ - 1);
    localparam logic [c_BCW-1:0] c_LAST_BEAT = c_BCW'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_grant_id;
    logic [c_BCW-1:0]   r_beat_cnt;

    logic               w_hit;
    logic [IDW-1:0]     w_hit_id;
    logic               w_in_grant;
    logic               w_cur_valid;
    logic               w_xfer;
    logic               w_release;
    logic [IDW-1:0]     w_next_ptr;
    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_slice[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Scan from r_ptr upward; iterating downward lets the nearest hit win.
    always_comb begin
        int v_idx;
        w_hit    = 1'b0;
        w_hit_id = '0;
        v_idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (bus.req_valid[v_idx[IDW-1:0]]) begin
                w_hit    = 1'b1;
                w_hit_id = v_idx[IDW-1:0];
            end
        end
    end

    assign w_in_grant  = (r_state == ST_GRANT);
    assign w_cur_valid = bus.req_valid[r_grant_id];
    assign w_xfer      = w_in_grant & w_cur_valid & ~bus.fifo_full & ~rst;
    assign w_release   = ~w_cur_valid | (w_xfer & (r_beat_cnt == c_LAST_BEAT));
    assign w_next_ptr  = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ARB;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_hit) begin
                        r_grant_id <= w_hit_id;
                        r_beat_cnt <= '0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state <= ST_ARB;
                        r_ptr   <= w_next_ptr;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = w_xfer && (r_grant_id == IDW'(i));
        end
    end

    assign bus.grant_valid = w_in_grant;
    assign bus.grant_id    = r_grant_id;
    assign bus.fifo_cs     = w_in_grant;
    assign bus.fifo_wr_en  = w_xfer;
    assign bus.fifo_datain = (w_in_grant & ~rst) ? w_slice[r_grant_id] : '0;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_grant_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_grant_cnt <= '0;
        end else begin
            if (w_in_grant && w_cur_valid && bus.fifo_full && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if ((r_state == ST_ARB) && w_hit && (r_grant_cnt != 16'hFFFF)) begin
                r_grant_cnt <= r_grant_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign grant_cnt = r_grant_cnt;
`endif

endmodule
`default_nettype wire
